div_unit: RTL and testbench

Iterative radix-2 integer divider implementing RV32M DIV/DIVU/REM/REMU. It sits in the EX stage beside the basic ALU and feeds the DIV_RESULT leg of the ALU result mux. It accepts one operation at a time, holds busy while computing, and presents a registered result. The hazard unit stalls IF/ID/EX until the result is retired.

---
 rtl/core_pkg.sv | 28 ++
 rtl/div_lzc.sv | 20 ++
 rtl/div_unit.sv | 169 ++++++++++++++++
 tb/tb_div_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared types and helpers for the EX-stage divider.
//   div_op_t    : RV32M divide/remainder operation select
//   div_state_t : divider controller states
//   div_is_signed / div_is_rem : operation decode helpers
package core_pkg;

  typedef enum logic [1:0] {
    DIV_DIV  = 2'd0,
    DIV_DIVU = 2'd1,
    DIV_REM  = 2'd2,
    DIV_REMU = 2'd3
  } div_op_t;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  function automatic logic div_is_signed(input div_op_t op);
    return (op == DIV_DIV) || (op == DIV_REM);
  endfunction

  function automatic logic div_is_rem(input div_op_t op);
    return (op == DIV_REM) || (op == DIV_REMU);
  endfunction

endpackage

// File: rtl/div_lzc.sv
// div_lzc: combinational leading-zero counter.
//   data  : value to inspect (WIDTH bits)
//   count : number of leading zeros, WIDTH when data is zero
module div_lzc #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] count
);

  // Scanning upward lets the highest set bit overwrite earlier matches.
  always_comb begin
    count = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (data[i]) count = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start_i    : request an operation (taken in IDLE, or in DONE with ack_i)
//   op_i       : div_op_t operation select
//   rs1_i      : dividend, rs2_i : divisor
//   kill_i     : flush; aborts everything, wins over start_i/ack_i
//   ack_i      : consumer has taken the result
//   busy_o     : high in CALC and DONE
//   valid_o    : result_o valid (DONE only)
//   result_o   : registered quotient or remainder
// Build option: define DIV_EARLY_OUT_EN to skip the dividend's leading zeros
// (latency WIDTH-L+1 instead of WIDTH+1); results are identical.
//
// Handshake: valid_o rises when the result is registered and stays high with
// result_o stable until an edge where ack_i (or kill_i) is high. ack_i with
// start_i on that edge retires this result and accepts the next operation.
module div_unit
  import core_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  div_op_t          op_i,
  input  logic [WIDTH-1:0] rs1_i,
  input  logic [WIDTH-1:0] rs2_i,
  input  logic             kill_i,
  input  logic             ack_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       state_q, state_d;
  logic             rem_sel_q, q_neg_q, r_neg_q;
  logic [WIDTH-1:0] dvd_q;  // dividend bits shift out the top, quotient bits in the bottom
  logic [WIDTH-1:0] dvs_q;  // divisor magnitude
  logic [WIDTH-1:0] rem_q;  // partial remainder, always < dvs_q between steps
  logic [CNT_W-1:0] cnt_q;  // steps left; 0 means the next CALC edge enters DONE

  // ---------------- operand preparation at accept ----------------
  logic             accept, sgn, sign_a, sign_b, div_zero, ovf;
  logic [WIDTH-1:0] abs_a, abs_b, dvd_load;
  logic [CNT_W-1:0] cnt_load;

  assign accept   = !kill_i && start_i &&
                    ((state_q == DIV_IDLE) || ((state_q == DIV_DONE) && ack_i));
  assign sgn      = div_is_signed(op_i);
  assign sign_a   = sgn & rs1_i[WIDTH-1];
  assign sign_b   = sgn & rs2_i[WIDTH-1];
  assign abs_a    = sign_a ? -rs1_i : rs1_i;
  assign abs_b    = sign_b ? -rs2_i : rs2_i;
  assign div_zero = (rs2_i == '0);
  assign ovf      = sgn && (rs1_i == MIN_NEG) && (rs2_i == '1);

`ifdef DIV_EARLY_OUT_EN
  logic [CNT_W-1:0] lz;

  div_lzc #(.WIDTH(WIDTH)) u_lzc (
    .data  (abs_a),
    .count (lz)
  );

  // Skipped steps would only shift zeros into the remainder and quotient.
  assign dvd_load = abs_a << lz;
  assign cnt_load = (lz == CNT_W'(WIDTH)) ? CNT_W'(1) : (CNT_W'(WIDTH) - lz);
`else
  assign dvd_load = abs_a;
  assign cnt_load = CNT_W'(WIDTH);
`endif

  // ---------------- one restoring step ----------------
  // The shifted remainder needs WIDTH+1 bits; the difference fits in WIDTH+1
  // bits as two's complement, so its top bit is the borrow.
  logic [WIDTH:0]   rem_sh, diff;
  logic             ge;
  logic [WIDTH-1:0] rem_step, dvd_step;

  assign rem_sh   = {rem_q, dvd_q[WIDTH-1]};
  assign diff     = rem_sh - {1'b0, dvs_q};
  assign ge       = ~diff[WIDTH];
  assign rem_step = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign dvd_step = {dvd_q[WIDTH-2:0], ge};

  // ---------------- sign correction on entry to DONE ----------------
  logic [WIDTH-1:0] quo_fix, rem_fix, result_d;

  assign quo_fix  = q_neg_q ? -dvd_q : dvd_q;
  assign rem_fix  = r_neg_q ? -rem_q : rem_q;
  assign result_d = rem_sel_q ? rem_fix : quo_fix;

  // ---------------- controller ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= DIV_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (kill_i) begin
      state_d = DIV_IDLE;
    end else begin
      case (state_q)
        DIV_IDLE: if (accept) state_d = DIV_CALC;
        DIV_CALC: if (cnt_q == '0) state_d = DIV_DONE;
        DIV_DONE: begin
          if (accept)     state_d = DIV_CALC;
          else if (ack_i) state_d = DIV_IDLE;
        end
        default:  state_d = DIV_IDLE;
      endcase
    end
  end

  assign busy_o  = (state_q != DIV_IDLE);
  assign valid_o = (state_q == DIV_DONE);

  // ---------------- datapath ----------------
  // Special cases preload the final quotient/remainder with no sign
  // correction and a zero count, so they reach DONE one edge after accept
  // through the same path as a normal division.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_sel_q <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      result_o  <= '0;
    end else if (accept) begin
      rem_sel_q <= div_is_rem(op_i);
      dvs_q     <= abs_b;
      if (div_zero) begin
        dvd_q   <= '1;
        rem_q   <= rs1_i;
        q_neg_q <= 1'b0;
        r_neg_q <= 1'b0;
        cnt_q   <= '0;
      end else if (ovf) begin
        dvd_q   <= rs1_i;
        rem_q   <= '0;
        q_neg_q <= 1'b0;
        r_neg_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        dvd_q   <= dvd_load;
        rem_q   <= '0;
        q_neg_q <= sign_a ^ sign_b;
        r_neg_q <= sign_a;
        cnt_q   <= cnt_load;
      end
    end else if ((state_q == DIV_CALC) && !kill_i) begin
      if (cnt_q != '0) begin
        rem_q <= rem_step;
        dvd_q <= dvd_step;
        cnt_q <= cnt_q - CNT_W'(1);
      end else begin
        result_o <= result_d;
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;
  import core_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  logic    start_i = 1'b0;
  logic    kill_i = 1'b0;
  logic    ack_i = 1'b0;
  div_op_t op_i = DIV_DIV;
  logic [W-1:0] rs1_i = '0;
  logic [W-1:0] rs2_i = '0;
  logic         busy_o, valid_o;
  logic [W-1:0] result_o;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .op_i     (op_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .kill_i   (kill_i),
    .ack_i    (ack_i),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .result_o (result_o)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  logic [W-1:0] last_exp;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic is_special(input div_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic s;
    s = (op == DIV_DIV) || (op == DIV_REM);
    return (b == 0) || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [W-1:0] ref_result(input div_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W-1:0] sa, sb, sr;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      DIV_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      DIV_REMU: return (b == 0) ? a : a % b;
      DIV_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf)    return a;
        sr = sa / sb;
        return sr;
      end
      default: begin
        if (b == 0) return a;
        if (ovf)    return '0;
        sr = sa % sb;
        return sr;
      end
    endcase
  endfunction

  // Edges from the accepting edge until valid_o is seen.
  function automatic int ref_latency(input div_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef DIV_EARLY_OUT_EN
    logic [W-1:0] m;
    int n;
`endif
    if (is_special(op, a, b)) return 1;
`ifdef DIV_EARLY_OUT_EN
    m = (((op == DIV_DIV) || (op == DIV_REM)) && a[W-1]) ? -a : a;
    n = 0;
    while (m != 0) begin
      m = m >> 1;
      n++;
    end
    if (n == 0) n = 1;
    return n + 1;
`else
    return W + 1;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input div_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start_i = 1'b1;
    op_i    = op;
    rs1_i   = a;
    rs2_i   = b;
    exp_q.push_back(ref_result(op, a, b));
    lat_q.push_back(ref_latency(op, a, b));
    @(posedge clk);
    #1;
    start_i = 1'b0;
    check("accept_busy", W'(busy_o), 1);
    check("accept_valid", W'(valid_o), 0);
  endtask

  task automatic wait_result(input string tag, input bit do_ack);
    int edges;
    int exp_l;
    edges    = 0;
    last_exp = exp_q.pop_front();
    exp_l    = lat_q.pop_front();
    while (!valid_o && edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check({tag, "_valid"}, W'(valid_o), 1);
    check({tag, "_latency"}, W'(edges), W'(exp_l));
    check({tag, "_result"}, result_o, last_exp);
    if (do_ack) begin
      @(negedge clk);
      ack_i = 1'b1;
      @(posedge clk);
      #1;
      ack_i = 1'b0;
      check({tag, "_retire_valid"}, W'(valid_o), 0);
      check({tag, "_retire_busy"}, W'(busy_o), 0);
    end
  endtask

  task automatic run(input string tag, input div_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
    issue(op, a, b);
    wait_result(tag, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic any_valid;
    logic [W-1:0] a, b;
    div_op_t op;

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", W'(busy_o), 0);
    check("reset_valid", W'(valid_o), 0);
    check("reset_result", result_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run("div_neg",   DIV_DIV,  32'hFFFF_FFEC, 32'd3);
    run("rem_neg",   DIV_REM,  32'hFFFF_FFEC, 32'd3);
    run("divu_zero", DIV_DIVU, 32'hFFFF_FFFF, 32'd0);
    run("remu_zero", DIV_REMU, 32'hFFFF_FFFF, 32'd0);
    run("div_zero",  DIV_DIV,  32'hFFFF_FFF0, 32'd0);
    run("rem_zero",  DIV_REM,  32'hFFFF_FFF0, 32'd0);
    run("div_ovf",   DIV_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
    run("rem_ovf",   DIV_REM,  32'h8000_0000, 32'hFFFF_FFFF);
    run("divu_100_7", DIV_DIVU, 32'd100, 32'd7);
    run("divu_0_5",  DIV_DIVU, 32'd0, 32'd5);
    run("div_min_m2", DIV_DIV, 32'h8000_0000, 32'hFFFF_FFFE);
    run("remu_big",  DIV_REMU, 32'hFFFF_FFFF, 32'h8000_0000);

    // Kill in the middle of CALC with start_i also high
    issue(DIV_DIVU, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    @(negedge clk);
    kill_i  = 1'b1;
    start_i = 1'b1;
    op_i    = DIV_DIV;
    rs1_i   = 32'd77;
    rs2_i   = 32'd5;
    @(posedge clk);
    #1;
    kill_i  = 1'b0;
    start_i = 1'b0;
    void'(exp_q.pop_back());
    void'(lat_q.pop_back());
    check("kill_busy", W'(busy_o), 0);
    check("kill_valid", W'(valid_o), 0);
    any_valid = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      any_valid = any_valid | valid_o | busy_o;
    end
    check("kill_stays_idle", W'(any_valid), 0);
    run("after_kill", DIV_DIV, 32'd77, 32'd5);

    // DONE held without ack: result stable, start ignored
    issue(DIV_REM, 32'hFFFF_FFF9, 32'd2);
    wait_result("hold", 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start_i = 1'b1;
      op_i    = DIV_DIVU;
      rs1_i   = 32'd55;
      rs2_i   = 32'd5;
      @(posedge clk);
      #1;
      check("hold_valid", W'(valid_o), 1);
      check("hold_result", result_o, last_exp);
    end
    // ack together with start retires and accepts on the same edge
    @(negedge clk);
    ack_i   = 1'b1;
    start_i = 1'b1;
    op_i    = DIV_DIVU;
    rs1_i   = 32'd100;
    rs2_i   = 32'd7;
    exp_q.push_back(ref_result(DIV_DIVU, 32'd100, 32'd7));
    lat_q.push_back(ref_latency(DIV_DIVU, 32'd100, 32'd7));
    @(posedge clk);
    #1;
    ack_i   = 1'b0;
    start_i = 1'b0;
    check("ackstart_valid", W'(valid_o), 0);
    check("ackstart_busy", W'(busy_o), 1);
    wait_result("ackstart", 1'b1);

    // Randomized operations with a bias toward boundary operands
    for (int n = 0; n < 60; n++) begin
      op = div_op_t'($urandom_range(0, 3));
      a  = $urandom();
      b  = $urandom();
      case ($urandom_range(0, 5))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
        3: begin a = -$urandom_range(0, 300); b = -$urandom_range(1, 20); end
        4: b = $urandom_range(1, 7);
        default: ;
      endcase
      run("rand", op, a, b);
    end

    // Asynchronous reset mid-operation
    issue(DIV_DIVU, 32'd12345, 32'd11);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_busy", W'(busy_o), 0);
    check("midreset_valid", W'(valid_o), 0);
    check("midreset_result", result_o, 0);
    void'(exp_q.pop_back());
    void'(lat_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    run("after_reset", DIV_REM, 32'd12345, 32'hFFFF_FFF5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
